// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: key handshake, flush and round-key read bus of the key schedule controller.
interface aes_key_sched_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic                      key_valid;
    logic                      key_ready;
    logic [4*DATA_WIDTH-1:0]   key_in;
    logic                      flush;
    logic                      keys_valid;
    logic                      rk_rd_en;
    logic [3:0]                rk_rd_idx;
    logic [4*DATA_WIDTH-1:0]   rk_rd_data;
    modport master (output key_valid, key_in, flush, rk_rd_en, rk_rd_idx,
                    input  key_ready, keys_valid, rk_rd_data);
    modport slave  (input  key_valid, key_in, flush, rk_rd_en, rk_rd_idx,
                    output key_ready, keys_valid, rk_rd_data);
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences an external Key_Expansion core and stores the 11 AES-128 round keys.
// Optional KEY_REUSE_EN: a key re-offered in DONE that matches the stored key is accepted without re-expansion.
module aes_key_sched_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_sched_ctrl_if.slave    bus,
    output logic [2:0]             ke_fsm_out,
    output logic [3:0]             ke_count_out,
    output logic [DATA_WIDTH-1:0]  ke_data_out_0,
    output logic [DATA_WIDTH-1:0]  ke_data_out_1,
    output logic [DATA_WIDTH-1:0]  ke_data_out_2,
    output logic [DATA_WIDTH-1:0]  ke_data_out_3,
    input  logic [DATA_WIDTH-1:0]  ke_data_in_0,
    input  logic [DATA_WIDTH-1:0]  ke_data_in_1,
    input  logic [DATA_WIDTH-1:0]  ke_data_in_2,
    input  logic [DATA_WIDTH-1:0]  ke_data_in_3
);
    localparam int KW = 4 * DATA_WIDTH;
    typedef enum logic [2:0] {IDLE, LOAD, ARM, EXPAND, DONE} state_t;
    state_t         state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic [KW-1:0]  key_q;
    logic [KW-1:0]  rk [0:10];
    logic           alive, hs, reuse, start;
    assign hs = bus.key_valid && bus.key_ready;
`ifdef KEY_REUSE_EN
    assign reuse = (state == DONE) && (bus.key_in == key_q);
`else
    assign reuse = 1'b0;
`endif
    assign start = hs && !reuse && !bus.flush;
    assign bus.key_ready = alive && (state == IDLE || state == DONE);
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + 4'd1;
        ke_fsm_out    = 3'b000;
        ke_count_out  = 4'd0;
        ke_data_out_0 = '0;
        ke_data_out_1 = '0;
        ke_data_out_2 = '0;
        ke_data_out_3 = '0;
        case (state)
            IDLE, DONE: state_nx = start ? LOAD : state;
            LOAD: begin
                ke_fsm_out    = 3'b001;
                ke_data_out_0 = key_q[4*DATA_WIDTH-1 -: DATA_WIDTH];
                ke_data_out_1 = key_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
                ke_data_out_2 = key_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
                ke_data_out_3 = key_q[DATA_WIDTH-1 -: DATA_WIDTH];
                state_nx      = ARM;
                cnt_nx        = 4'd0;
            end
            ARM: begin
                ke_fsm_out = 3'b010;
                state_nx   = (cnt == 4'd1) ? EXPAND : ARM;
                cnt_nx     = (cnt == 4'd1) ? 4'd0 : cnt + 4'd1;
            end
            EXPAND: begin
                ke_fsm_out   = 3'b010;
                ke_count_out = (cnt > 4'd10) ? 4'd10 : cnt;
                state_nx     = (cnt == 4'd11) ? DONE : EXPAND;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            key_q          <= '0;
            alive          <= 1'b0;
            bus.keys_valid <= 1'b0;
            bus.rk_rd_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            alive <= 1'b1;
            if (start) key_q <= bus.key_in;
            if (bus.flush || start) bus.keys_valid <= 1'b0;
            else if (state == EXPAND && cnt == 4'd11) bus.keys_valid <= 1'b1;
            if (bus.flush) bus.rk_rd_data <= '0;
            else if (bus.rk_rd_en)
                bus.rk_rd_data <= (bus.rk_rd_idx <= 4'd10 && bus.keys_valid) ? rk[bus.rk_rd_idx] : '0;
        end
    end
    // Core output lags ke_count_out by one cycle, so EXPAND cycle n stores slot n-1.
    always_ff @(posedge clk) begin
        if (state == EXPAND && cnt != 4'd0)
            rk[cnt - 4'd1] <= {ke_data_in_0, ke_data_in_1, ke_data_in_2, ke_data_in_3};
    end
endmodule
